// File: rtl/select_encode_reg.sv
// Latches an instruction, decodes the Gra/Grb/Grc register field to one-hot load/drive enables and sign-extends immediate C.
// Enables, ba_zero and sel_err follow their inputs by one clock; there is no flow control, so every edge is accepted.
module select_encode_reg #(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = $clog2(NUM_REGS),
  parameter int RA_LSB   = 23,
  parameter int RB_LSB   = 19,
  parameter int RC_LSB   = 15,
  parameter int IMM_W    = 19
) (
  input  logic                clock,
  input  logic                clear_n,
  input  logic                ir_load,
  input  logic [31:0]         instruction,
  input  logic                Gra,
  input  logic                Grb,
  input  logic                Grc,
  input  logic                Rin,
  input  logic                Rout,
  input  logic                BAout,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                ba_zero,
  output logic                sel_err,
  output logic [31:0]         C_sign_extended
);

  logic [31:0]         ir_q, ir_d;
  logic [31:0]         c_sext_q, c_sext_d;
  logic [NUM_REGS-1:0] sel_q, sel_d;
  logic [NUM_REGS-1:0] reg_in_q, reg_in_d;
  logic [NUM_REGS-1:0] reg_out_q, reg_out_d;
  logic                ba_zero_q, ba_zero_d;
  logic                sel_err_q, sel_err_d;
  logic [SEL_W-1:0]    field_idx;
  logic                any_gr;
  logic                unused_ir;

  // Only the register fields of ir_q feed logic; the rest is architectural state.
  assign unused_ir = ^ir_q;

  always_comb begin
    ir_d     = ir_load ? instruction : ir_q;
    c_sext_d = ir_load ? {{(32-IMM_W){instruction[IMM_W-1]}}, instruction[IMM_W-1:0]}
                       : c_sext_q;
  end

  // Decode always looks at the latched word, so a same-edge ir_load affects the next edge.
  always_comb begin
    any_gr = Gra | Grb | Grc;
    if (Gra)      field_idx = ir_q[RA_LSB+SEL_W-1:RA_LSB];
    else if (Grb) field_idx = ir_q[RB_LSB+SEL_W-1:RB_LSB];
    else          field_idx = ir_q[RC_LSB+SEL_W-1:RC_LSB];
  end

  always_comb begin
    sel_d     = '0;
    reg_in_d  = '0;
    reg_out_d = '0;
    ba_zero_d = 1'b0;
    sel_err_d = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
    if (any_gr) begin
      sel_d[field_idx] = 1'b1;
    end
    if (Rin) begin
      reg_in_d = sel_d;
    end
    if (Rout | BAout) begin
      reg_out_d = sel_d;
    end
    // BAout on R0 means "base address zero": suppress R0 and drive the constant instead.
    if (BAout && !Rout && sel_d[0]) begin
      reg_out_d[0] = 1'b0;
      ba_zero_d    = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      ir_q      <= '0;
      c_sext_q  <= '0;
      sel_q     <= '0;
      reg_in_q  <= '0;
      reg_out_q <= '0;
      ba_zero_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      c_sext_q  <= c_sext_d;
      sel_q     <= sel_d;
      reg_in_q  <= reg_in_d;
      reg_out_q <= reg_out_d;
      ba_zero_q <= ba_zero_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign reg_in          = reg_in_q;
  assign reg_out         = reg_out_q;
  assign ba_zero         = ba_zero_q;
  assign sel_err         = sel_err_q;
  assign C_sign_extended = c_sext_q;

endmodule

// File: tb/tb_select_encode_reg.sv
// Directed and random stimulus for select_encode_reg at 16 and 32 registers, checked against an arithmetic reference model.
module tb_select_encode_reg;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        ir_load = 1'b0;
  logic [31:0] instruction = '0;
  logic        gra = 1'b0, grb = 1'b0, grc = 1'b0;
  logic        rin = 1'b0, rout = 1'b0, baout = 1'b0;

  logic [15:0] reg_in_a, reg_out_a;
  logic        ba_zero_a, sel_err_a;
  logic [31:0] c_a;
  logic [31:0] reg_in_b, reg_out_b;
  logic        ba_zero_b, sel_err_b;
  logic [31:0] c_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] ir_m, c_m;
  logic [31:0] e_in_a, e_out_a, e_in_b, e_out_b;
  logic        e_ba_a, e_ba_b, e_err;

  always #5 clock = ~clock;

  select_encode_reg #(.NUM_REGS(16)) dut_a (
    .clock(clock), .clear_n(clear_n), .ir_load(ir_load), .instruction(instruction),
    .Gra(gra), .Grb(grb), .Grc(grc), .Rin(rin), .Rout(rout), .BAout(baout),
    .reg_in(reg_in_a), .reg_out(reg_out_a), .ba_zero(ba_zero_a), .sel_err(sel_err_a),
    .C_sign_extended(c_a)
  );

  select_encode_reg #(.NUM_REGS(32)) dut_b (
    .clock(clock), .clear_n(clear_n), .ir_load(ir_load), .instruction(instruction),
    .Gra(gra), .Grb(grb), .Grc(grc), .Rin(rin), .Rout(rout), .BAout(baout),
    .reg_in(reg_in_b), .reg_out(reg_out_b), .ba_zero(ba_zero_b), .sel_err(sel_err_b),
    .C_sign_extended(c_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Register number picked by the highest-priority Gr, then the enables it implies.
  task automatic model(input int n, input logic [31:0] ir, input logic [2:0] gr,
                       input logic [2:0] st, output logic [31:0] e_in,
                       output logic [31:0] e_out, output logic e_ba);
    int lsb;
    int idx;
    logic [31:0] onehot;
    e_in = 0; e_out = 0; e_ba = 1'b0;
    if (gr != 3'b000) begin
      lsb = gr[2] ? 23 : (gr[1] ? 19 : 15);
      idx = int'((ir >> lsb) % n);
      onehot = 32'd1 << idx;
      if (st[2]) e_in = onehot;
      if (st[1]) e_out = onehot;
      else if (st[0]) begin
        if (idx == 0) e_ba = 1'b1;
        else e_out = onehot;
      end
    end
  endtask

  task automatic check_all();
    check("reg_in16", {16'h0, reg_in_a}, e_in_a);
    check("reg_out16", {16'h0, reg_out_a}, e_out_a);
    check("ba_zero16", {31'h0, ba_zero_a}, {31'h0, e_ba_a});
    check("sel_err16", {31'h0, sel_err_a}, {31'h0, e_err});
    check("csext16", c_a, c_m);
    check("reg_in32", reg_in_b, e_in_b);
    check("reg_out32", reg_out_b, e_out_b);
    check("ba_zero32", {31'h0, ba_zero_b}, {31'h0, e_ba_b});
    check("sel_err32", {31'h0, sel_err_b}, {31'h0, e_err});
    check("csext32", c_b, c_m);
    check("onehot_in", {31'h0, ($countones(reg_in_a) <= 1 && $countones(reg_in_b) <= 1)}, 32'd1);
    check("onehot_out", {31'h0, ($countones(reg_out_a) <= 1 && $countones(reg_out_b) <= 1)}, 32'd1);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare at the falling edge.
  task automatic step(input logic ld, input logic [31:0] ins, input logic [2:0] gr, input logic [2:0] st);
    int v;
    ir_load = ld; instruction = ins;
    {gra, grb, grc} = gr;
    {rin, rout, baout} = st;
    model(16, ir_m, gr, st, e_in_a, e_out_a, e_ba_a);
    model(32, ir_m, gr, st, e_in_b, e_out_b, e_ba_b);
    e_err = ($countones(gr) > 1);
    if (ld) begin
      ir_m = ins;
      v = int'(ins & 32'h7FFFF);
      if (v >= (1 << 18)) v = v - (1 << 19);
      c_m = v;
    end
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  initial begin
    ir_m = 0; c_m = 0;
    e_in_a = 0; e_out_a = 0; e_in_b = 0; e_out_b = 0;
    e_ba_a = 0; e_ba_b = 0; e_err = 0;

    #12;
    check_all();
    clear_n = 1'b1;

    step(1'b1, 32'h0A18_0000, 3'b000, 3'b000);
    step(1'b0, 32'h0, 3'b100, 3'b100);
    check("req22_in", {16'h0, reg_in_a}, 32'h0010);
    check("req22_out", {16'h0, reg_out_a}, 32'h0000);
    step(1'b0, 32'h0, 3'b110, 3'b010);
    check("req23_out", {16'h0, reg_out_a}, 32'h0010);
    check("req23_err", {31'h0, sel_err_a}, 32'd1);
    step(1'b0, 32'h0, 3'b000, 3'b011);
    check("req23_err_drop", {31'h0, sel_err_a}, 32'd0);
    check("nogr_out", {16'h0, reg_out_a}, 32'h0000);

    step(1'b1, 32'h0A00_0000, 3'b000, 3'b000);
    step(1'b0, 32'h0, 3'b010, 3'b001);
    check("req24_ba_out", {16'h0, reg_out_a}, 32'h0000);
    check("req24_ba", {31'h0, ba_zero_a}, 32'd1);
    step(1'b0, 32'h0, 3'b010, 3'b011);
    check("req24_rout_out", {16'h0, reg_out_a}, 32'h0001);
    check("req24_rout_ba", {31'h0, ba_zero_a}, 32'd0);

    step(1'b1, 32'h0007_FFFF, 3'b000, 3'b000);
    check("req25_neg", c_a, 32'hFFFF_FFFF);
    step(1'b1, 32'h0003_FFFF, 3'b000, 3'b000);
    check("req25_pos", c_a, 32'h0003_FFFF);

    step(1'b1, 32'h0A18_0000, 3'b100, 3'b100);
    check("req17_old_ir", {16'h0, reg_in_a}, 32'h0001);
    step(1'b0, 32'h0, 3'b100, 3'b100);
    check("req17_new_ir", {16'h0, reg_in_a}, 32'h0010);

    step(1'b1, 32'h0F80_0000, 3'b000, 3'b000);
    step(1'b0, 32'h0, 3'b100, 3'b010);
    check("req27_out32", reg_out_b, 32'h8000_0000);
    check("req27_out16", {16'h0, reg_out_a}, 32'h8000);

    for (int i = 0; i < 300; i++) begin
      step(($urandom % 4) == 0, $urandom, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    step(1'b1, 32'h0007_FFFF, 3'b100, 3'b100);
    step(1'b0, 32'h0, 3'b110, 3'b100);
    #2 clear_n = 1'b0;
    #1;
    check("rst_async_in", {16'h0, reg_in_a}, 32'h0);
    check("rst_async_c", c_a, 32'h0);
    check("rst_async_err", {31'h0, sel_err_a}, 32'h0);
    @(posedge clock);
    #1;
    check("rst_held_in", reg_in_b, 32'h0);
    @(negedge clock);
    clear_n = 1'b1;
    #1;
    check("rst_release_in", {16'h0, reg_in_a}, 32'h0);
    check("rst_release_c", c_b, 32'h0);
    #1;
    ir_m = 0; c_m = 0;
    step(1'b0, 32'h0, 3'b100, 3'b100);
    check("post_rst_r0", {16'h0, reg_in_a}, 32'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/select_encode_reg.md
SELECT_ENCODE_REG -- requirements
Module: select_encode_reg

Interface
REQ-001 SHALL have parameter NUM_REGS, 16, register-file size; power of two, 2..32.
REQ-002 SHALL have parameter SEL_W, log2(NUM_REGS), register-field width.
REQ-003 SHALL have parameters RA_LSB 23, RB_LSB 19, RC_LSB 15, the LSB positions of the Ra/Rb/Rc fields in the instruction.
REQ-004 SHALL have parameter IMM_W, 19, width of immediate C at instruction[IMM_W-1:0]; 1..31.
REQ-005 SHALL have one clock; reset is asynchronous and active-low. Ports: clock, clear_n.
REQ-006 Ports SHALL be:
- clock  in  1  rising-edge clock
- clear_n  in  1  async active-low reset
- ir_load  in  1  capture instruction this edge
- instruction  in  32  instruction word from bus
- Gra, Grb, Grc  in  1 each  field select
- Rin, Rout, BAout  in  1 each  register strobes
- reg_in  out  NUM_REGS  one-hot register load enables
- reg_out  out  NUM_REGS  one-hot register drive enables
- ba_zero  out  1  drive constant 0 as base address (R0 under BAout)
- sel_err  out  1  more than one of Gra/Grb/Grc seen
- C_sign_extended  out  32  sign-extended immediate of latched instruction

Function
REQ-007 SHALL hold an internal 32-bit ir_q, loaded from instruction on a rising edge with ir_load=1; otherwise held.
REQ-008 Field decode SHALL use ir_q only, never live instruction.
REQ-009 Field choice SHALL be priority Gra > Grb > Grc (no bitwise merge); index = ir_q[RA_LSB+SEL_W-1:RA_LSB] etc.
REQ-010 sel_q (NUM_REGS, one-hot or zero) SHALL register, each edge, the decoded index when any Gr is 1, else all-zero.
REQ-011 Strobe latency SHALL be one cycle: on each edge reg_in <= sel_next & {Rin}, reg_out <= sel_next & {Rout|BAout}, where sel_next is the value loaded into sel_q that edge.
REQ-012 With no Gr asserted, reg_in and reg_out SHALL be all-zero next cycle regardless of strobes.
REQ-013 BAout with selected index 0: reg_out[0] SHALL be 0 and ba_zero SHALL be 1 next cycle; Rout=1 at same time forces reg_out[0]=1, ba_zero=0.
REQ-014 ba_zero SHALL be 0 in every other case.
REQ-015 Rin and Rout/BAout together SHALL both be honoured on the same register.
REQ-016 sel_err SHALL be a registered one-cycle pulse when two or more of Gra/Grb/Grc are 1; selection still follows REQ-009.
REQ-017 ir_load and Gr* same edge: decode SHALL use the old ir_q; new fields take effect the following edge.
REQ-018 C_sign_extended SHALL be registered: loaded with sign extension of instruction[IMM_W-1:0] on the ir_load edge, bits 31:IMM_W equal to bit IMM_W-1.
REQ-019 Popcount of reg_in and of reg_out SHALL never exceed 1.

Reset
REQ-020 clear_n=0 SHALL asynchronously clear ir_q, sel_q, reg_in, reg_out, ba_zero, sel_err, C_sign_extended to 0.
REQ-021 Release SHALL take effect at the first rising edge with clear_n=1; assertion mid-operation SHALL drop all enables immediately.

Verification
REQ-022 ir_load with instruction 0x0A180000 (Ra=4, Rb=3, Rc=0), then Gra+Rin next cycle -> reg_in=0x0010 one cycle later, reg_out=0.
REQ-023 Same ir_q, Grb+Gra+Rout -> reg_out=0x0010 (Ra wins), sel_err=1 for one cycle.
REQ-024 Instruction with Rb=0, Grb+BAout -> reg_out=0, ba_zero=1; Grb+BAout+Rout -> reg_out=0x0001, ba_zero=0.
REQ-025 ir_load with instruction[18:0]=0x7FFFF -> C_sign_extended=0xFFFFFFFF; 0x3FFFF -> 0x0003FFFF.
REQ-026 Gra+Rin active, clear_n pulsed low between edges -> reg_in, C_sign_extended, sel_err go 0 without a clock edge; stay 0 until first edge after release.
REQ-027 NUM_REGS=32 (SEL_W=5), Ra=31, Gra+Rout -> reg_out=0x80000000.
